// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - dual-write, multi-read register file with busy scoreboard
module reg_file_mp #(
  parameter int W        = 8,
  parameter int A        = 4,
  parameter int NR       = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            WriteEnA,
  input  logic [A-1:0]    WaddrA,
  input  logic [W-1:0]    DataInA,
  input  logic            WriteEnB,
  input  logic [A-1:0]    WaddrB,
  input  logic [W-1:0]    DataInB,
  input  logic            ReserveEn,
  input  logic [A-1:0]    ReserveAddr,
  input  logic [NR*A-1:0] RaddrFlat,
  output logic [NR*W-1:0] DataOutFlat,
  output logic [NR-1:0]   BusyFlat,
  output logic            AnyBusy
);

  localparam int DEPTH = 2 ** A;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // A reserve in the same cycle as a write wins: the new producer supersedes the old.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r]  = mem_q[r];
      busy_d[r] = busy_q[r];
      if (WriteEnB && (WaddrB == A'(r))) begin
        mem_d[r] = DataInB;
      end else if (WriteEnA && (WaddrA == A'(r))) begin
        mem_d[r] = DataInA;
      end
      if (ReserveEn && (ReserveAddr == A'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((WriteEnA && (WaddrA == A'(r))) || (WriteEnB && (WaddrB == A'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [A-1:0] raddr;
    logic         hit_a;
    logic         hit_b;
    logic         is_zero;
    logic [W-1:0] rdata;
    logic         rbusy;

    assign raddr   = RaddrFlat[i*A +: A];
    assign hit_a   = (BYPASS != 0) && WriteEnA && (WaddrA == raddr);
    assign hit_b   = (BYPASS != 0) && WriteEnB && (WaddrB == raddr);
    assign is_zero = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
      rdata = mem_q[raddr];
      rbusy = busy_q[raddr];
      if (hit_b) begin
        rdata = DataInB;
      end else if (hit_a) begin
        rdata = DataInA;
      end
      if (hit_a || hit_b) begin
        rbusy = 1'b0;
      end
      if (is_zero) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign DataOutFlat[i*W +: W] = rdata;
    assign BusyFlat[i]           = rbusy;
  end

  assign AnyBusy = |busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we_a, we_b, res_en;
  logic [3:0]  wa_a, wa_b, res_addr;
  logic [7:0]  di_a, di_b;
  logic [7:0]  raddr2;
  logic [15:0] raddr4;
  logic [15:0] dout2, nb_dout2;
  logic [1:0]  busy2, nb_busy2;
  logic        any2, nb_any, z_any;
  logic [31:0] z_dout4;
  logic [3:0]  z_busy4;

  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.W(8), .A(4), .NR(2), .BYPASS(1), .ZERO_REG(0)) dut (
    .Clk(clk), .ResetN(resetn),
    .WriteEnA(we_a), .WaddrA(wa_a), .DataInA(di_a),
    .WriteEnB(we_b), .WaddrB(wa_b), .DataInB(di_b),
    .ReserveEn(res_en), .ReserveAddr(res_addr),
    .RaddrFlat(raddr2), .DataOutFlat(dout2), .BusyFlat(busy2), .AnyBusy(any2)
  );

  reg_file_mp #(.W(8), .A(4), .NR(2), .BYPASS(0), .ZERO_REG(0)) dut_nb (
    .Clk(clk), .ResetN(resetn),
    .WriteEnA(we_a), .WaddrA(wa_a), .DataInA(di_a),
    .WriteEnB(we_b), .WaddrB(wa_b), .DataInB(di_b),
    .ReserveEn(res_en), .ReserveAddr(res_addr),
    .RaddrFlat(raddr2), .DataOutFlat(nb_dout2), .BusyFlat(nb_busy2), .AnyBusy(nb_any)
  );

  reg_file_mp #(.W(8), .A(4), .NR(4), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .Clk(clk), .ResetN(resetn),
    .WriteEnA(we_a), .WaddrA(wa_a), .DataInA(di_a),
    .WriteEnB(we_b), .WaddrB(wa_b), .DataInB(di_b),
    .ReserveEn(res_en), .ReserveAddr(res_addr),
    .RaddrFlat(raddr4), .DataOutFlat(z_dout4), .BusyFlat(z_busy4), .AnyBusy(z_any)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a   = 1'b0;
    we_b   = 1'b0;
    res_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs[$];
    we_a = 1'b1; wa_a = 4'd3;  di_a = 8'hA5;
    we_b = 1'b1; wa_b = 4'd12; di_b = 8'h3C;
    step(); idle();
    raddr2 = {4'd12, 4'd3};
    #1;
    sb.push_back('{"preload", 32'h3CA5}); obs.push_back(32'(dout2));
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int a = 0; a < 16; a++) begin
      raddr2 = {2{4'(a)}};
      raddr4 = {4{4'(a)}};
      #1;
      sb.push_back('{"rst_dout", 32'h0});    obs.push_back(32'(dout2));
      sb.push_back('{"rst_dout_nb", 32'h0}); obs.push_back(32'(nb_dout2));
      sb.push_back('{"rst_dout_z", 32'h0});  obs.push_back(z_dout4);
      sb.push_back('{"rst_busy", 32'h0});    obs.push_back(32'({busy2, nb_busy2, z_busy4}));
    end
    sb.push_back('{"rst_anybusy", 32'h0}); obs.push_back(32'({any2, nb_any, z_any}));
    for (int k = 0; k < obs.size(); k++) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (obs[k] !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs[k], e.v);
      end
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] obs[$];
    we_a = 1'b1; wa_a = 4'd2; di_a = 8'h11;
    we_b = 1'b1; wa_b = 4'd5; di_b = 8'h22;
    step(); idle();
    raddr2 = {4'd5, 4'd2};
    #1;
    sb.push_back('{"dual_diff", 32'h2211});    obs.push_back(32'(dout2));
    sb.push_back('{"dual_diff_nb", 32'h2211}); obs.push_back(32'(nb_dout2));
    we_a = 1'b1; wa_a = 4'd7; di_a = 8'h33;
    we_b = 1'b1; wa_b = 4'd7; di_b = 8'h44;
    step(); idle();
    raddr2 = {4'd7, 4'd7};
    #1;
    sb.push_back('{"dual_same", 32'h4444});    obs.push_back(32'(dout2));
    sb.push_back('{"dual_same_nb", 32'h4444}); obs.push_back(32'(nb_dout2));
    for (int k = 0; k < obs.size(); k++) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (obs[k] !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs[k], e.v);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] obs[$];
    we_a = 1'b1; wa_a = 4'd4; di_a = 8'h10;
    step(); idle();
    raddr2 = {4'd8, 4'd4};
    we_b = 1'b1; wa_b = 4'd4; di_b = 8'h99;
    we_a = 1'b1; wa_a = 4'd8; di_a = 8'h01;
    #1;
    sb.push_back('{"byp_same_cycle", 32'h0199}); obs.push_back(32'(dout2));
    sb.push_back('{"nobyp_same_cycle", 32'h0010}); obs.push_back(32'(nb_dout2));
    step(); idle();
    #1;
    sb.push_back('{"byp_next", 32'h0199});   obs.push_back(32'(dout2));
    sb.push_back('{"nobyp_next", 32'h0199}); obs.push_back(32'(nb_dout2));
    we_a = 1'b1; wa_a = 4'd8; di_a = 8'h55;
    we_b = 1'b1; wa_b = 4'd8; di_b = 8'h66;
    #1;
    sb.push_back('{"byp_b_over_a", 32'h6699}); obs.push_back(32'(dout2));
    sb.push_back('{"nobyp_b_over_a", 32'h0199}); obs.push_back(32'(nb_dout2));
    step(); idle();
    #1;
    sb.push_back('{"nobyp_b_stored", 32'h6699}); obs.push_back(32'(nb_dout2));
    for (int k = 0; k < obs.size(); k++) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (obs[k] !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs[k], e.v);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [31:0] obs[$];
    res_en = 1'b1; res_addr = 4'd6;
    step(); idle();
    raddr2 = {4'd6, 4'd6};
    #1;
    sb.push_back('{"resv_busy", 32'h3});    obs.push_back(32'(busy2));
    sb.push_back('{"resv_busy_nb", 32'h3}); obs.push_back(32'(nb_busy2));
    sb.push_back('{"resv_any", 32'h1});     obs.push_back(32'(any2));
    we_a = 1'b1; wa_a = 4'd6; di_a = 8'h5A;
    #1;
    sb.push_back('{"wr_busy_byp", 32'h0});   obs.push_back(32'(busy2));
    sb.push_back('{"wr_busy_nobyp", 32'h3}); obs.push_back(32'(nb_busy2));
    sb.push_back('{"wr_any_reg", 32'h1});    obs.push_back(32'(any2));
    step(); idle();
    #1;
    sb.push_back('{"cleared_busy", 32'h0});  obs.push_back(32'({busy2, nb_busy2}));
    sb.push_back('{"cleared_any", 32'h0});   obs.push_back(32'(any2));
    sb.push_back('{"cleared_data", 32'h5A5A}); obs.push_back(32'(dout2));
    res_en = 1'b1; res_addr = 4'd6;
    we_b = 1'b1; wa_b = 4'd6; di_b = 8'h77;
    step(); idle();
    #1;
    sb.push_back('{"resv_wr_data", 32'h7777}); obs.push_back(32'(dout2));
    sb.push_back('{"resv_wr_busy", 32'h3});    obs.push_back(32'(busy2));
    sb.push_back('{"resv_wr_any", 32'h1});     obs.push_back(32'(any2));
    res_en = 1'b1; res_addr = 4'd6;
    step(); idle();
    #1;
    sb.push_back('{"re_resv_busy", 32'h3}); obs.push_back(32'(busy2));
    we_a = 1'b1; wa_a = 4'd6; di_a = 8'h78;
    step(); idle();
    #1;
    sb.push_back('{"final_busy", 32'h0}); obs.push_back(32'(busy2));
    sb.push_back('{"final_any", 32'h0});  obs.push_back(32'(any2));
    for (int k = 0; k < obs.size(); k++) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (obs[k] !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs[k], e.v);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] obs[$];
    raddr2 = 8'h00;
    raddr4 = 16'h0000;
    we_a = 1'b1; wa_a = 4'd0; di_a = 8'hFF;
    res_en = 1'b1; res_addr = 4'd0;
    #1;
    sb.push_back('{"z_byp_data", 32'h0});   obs.push_back(z_dout4);
    sb.push_back('{"z_byp_busy", 32'h0});   obs.push_back(32'(z_busy4));
    sb.push_back('{"nz_byp_data", 32'hFFFF}); obs.push_back(32'(dout2));
    step(); idle();
    #1;
    sb.push_back('{"z_r0_data", 32'h0});    obs.push_back(z_dout4);
    sb.push_back('{"z_r0_busy", 32'h0});    obs.push_back(32'(z_busy4));
    sb.push_back('{"z_any", 32'h0});        obs.push_back(32'(z_any));
    sb.push_back('{"nz_r0_data", 32'hFFFF}); obs.push_back(32'(dout2));
    sb.push_back('{"nz_r0_busy", 32'h3});   obs.push_back(32'(busy2));
    we_a = 1'b1; wa_a = 4'd0; di_a = 8'h00;
    step(); idle();
    we_a = 1'b1; wa_a = 4'd1; di_a = 8'hA1;
    we_b = 1'b1; wa_b = 4'd2; di_b = 8'hB2;
    step();
    we_a = 1'b1; wa_a = 4'd3; di_a = 8'hC3;
    we_b = 1'b1; wa_b = 4'd4; di_b = 8'hD4;
    step(); idle();
    raddr4 = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    sb.push_back('{"nr4_read_a", 32'hD4C3B2A1}); obs.push_back(z_dout4);
    raddr4 = {4'd1, 4'd0, 4'd15, 4'd3};
    #1;
    sb.push_back('{"nr4_read_b", 32'hA10000C3}); obs.push_back(z_dout4);
    for (int k = 0; k < obs.size(); k++) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (obs[k] !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs[k], e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs[$];
    res_en = 1'b1; res_addr = 4'd9;
    step(); idle();
    raddr2 = {4'd9, 4'd9};
    raddr4 = {4{4'd9}};
    #1;
    sb.push_back('{"mid_busy_pre", 32'h3});   obs.push_back(32'(busy2));
    sb.push_back('{"mid_busy_pre_z", 32'hF}); obs.push_back(32'(z_busy4));
    resetn = 1'b0;
    we_a = 1'b1; wa_a = 4'd9; di_a = 8'hEE;
    step();
    resetn = 1'b1;
    idle();
    #1;
    sb.push_back('{"mid_data", 32'h0});   obs.push_back(32'(dout2));
    sb.push_back('{"mid_data_z", 32'h0}); obs.push_back(z_dout4);
    sb.push_back('{"mid_busy", 32'h0});   obs.push_back(32'({busy2, z_busy4}));
    sb.push_back('{"mid_any", 32'h0});    obs.push_back(32'({any2, nb_any, z_any}));
    for (int k = 0; k < obs.size(); k++) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (obs[k] !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs[k], e.v);
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    idle();
    wa_a     = '0; wa_b = '0; di_a = '0; di_b = '0; res_addr = '0;
    raddr2   = '0;
    raddr4   = '0;
    step();
    step();
    resetn = 1'b1;
    test_reset();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file with two write ports and NR combinational read ports.
- Provides optional same-cycle write-to-read bypass and an optional hardwired-zero register 0.
- Keeps a per-register busy scoreboard, so the decode stage can detect pending multi-cycle producers.
- Sits between decode (read/reserve) and writeback (write ports A/B) in the processor datapath.

Parameters:
W, 8, data width in bits
A, 4, address width; depth = 2**A registers
NR, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read of an address being written this cycle returns the incoming data; 0 = returns the stored value
ZERO_REG, 0, 1 = register 0 always reads 0; writes and reserves to it are ignored

Ports:
Clk  input  1  rising-edge clock
ResetN  input  1  synchronous, active-low reset
WriteEnA  input  1  write port A enable
WaddrA  input  A  write port A address
DataInA  input  W  write port A data
WriteEnB  input  1  write port B enable; has priority over A
WaddrB  input  A  write port B address
DataInB  input  W  write port B data
ReserveEn  input  1  set busy bit of ReserveAddr
ReserveAddr  input  A  register being reserved
RaddrFlat  input  NR*A  read addresses; port i = bits [i*A +: A]
DataOutFlat  output  NR*W  read data; port i = bits [i*W +: W]
BusyFlat  output  NR  busy flag for each read port's address
AnyBusy  output  1  OR of all busy bits

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low. On a rising Clk edge with ResetN=0:
  - All 2**A registers clear to 0 (not only the low half).
  - All busy bits clear.
  - Write and reserve inputs are ignored in that cycle.
  - Outputs are combinational from state, so one edge after reset: DataOutFlat=0, BusyFlat=0, AnyBusy=0.
- Writes: take effect at the rising edge.
  - Both ports to the same address: B's data is stored, A's is discarded.
  - Different addresses: both are stored.
- Reads: combinational with zero latency.
  - BYPASS=1: if read port i's address matches an enabled write address this cycle, DataOut_i = incoming data. B matching wins over A matching; otherwise the stored value.
  - BYPASS=0: always the stored value.
- Scoreboard: busy[r] is a registered bit. At each edge, busy[r] becomes 1 if ReserveEn and ReserveAddr==r.
  - Otherwise it becomes 0 if any enabled write targets r; otherwise it holds.
  - Simultaneous reserve and write to the same r: data is written AND busy ends at 1 (a new producer supersedes).
  - Reserving an already-busy register keeps it busy (no counting).
- Busy outputs:
  - BusyFlat[i] = busy[Raddr_i], except with BYPASS=1 it reads 0 if an enabled write to that address occurs this cycle.
  - AnyBusy = OR of the registered busy bits only (no bypass term).
- ZERO_REG=1: address 0 reads data 0 and busy 0 on every port (bypass included). Writes to 0 are ignored, reserves to 0 are ignored, and storage is never modified.
- Widths: addresses are always in range (2**A entries), so there is no wrap or out-of-range case. Data is stored unmodified, with no sign handling.
- Reset mid-operation: pending reservations are dropped; a write in the same cycle as ResetN=0 is lost.

Test Plan:
- Reset: preload r3=0xA5 and r12=0x3C, pulse ResetN=0 for one edge -> every port reads 0x00 for all 16 addresses, BusyFlat=0, AnyBusy=0.
- Dual write: WA r2=0x11, WB r5=0x22 in one cycle -> next cycle r2=0x11, r5=0x22. Then WA and WB both to r7 (0x33/0x44) -> r7=0x44.
- Bypass (BYPASS=1): r4=0x10 stored; in one cycle WB r4=0x99 with read0 of r4 -> DataOut0=0x99 in the same cycle. With BYPASS=0 the same stimulus reads 0x10, then 0x99 the next cycle.
- Scoreboard: reserve r6 -> next cycle Busy=1 on port reading r6 and AnyBusy=1. Write r6=0x5A -> same cycle Busy=0 (BYPASS=1), registered busy clear next cycle. Reserve r6 plus write r6=0x77 in one cycle -> r6=0x77, busy stays 1.
- ZERO_REG=1: write r0=0xFF and reserve r0 -> r0 reads 0x00, Busy=0, AnyBusy unchanged. NR=4 with all ports reading different addresses returns the correct values independently.
- Reset mid-reservation: reserve r9, and assert ResetN=0 in the same cycle as a write r9=0xEE -> after reset r9=0x00, busy[r9]=0.
